// File: rtl/cgu_fdload_seq_if.sv
// cgu_fdload_seq_if: control, config and divider-bus bundle for the fdload sequencer.
// master = CGU register file side, slave = sequencer.
interface cgu_fdload_seq_if #(
  parameter int FDW  = 8,
  parameter int NDOM = 4
);
  logic                clk0en;
  logic                align;
  logic                cfg_req;
  logic [NDOM*FDW-1:0] cfg_fd0;
  logic [NDOM*FDW-1:0] cfg_fd2;
  logic [NDOM-1:0]     cfg_mask;
  logic [NDOM*FDW-1:0] fd0;
  logic [NDOM*FDW-1:0] fd2;
  logic [NDOM-1:0]     fdload;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output clk0en, align, cfg_req,
    output cfg_fd0, cfg_fd2, cfg_mask,
    input  fd0, fd2, fdload,
    input  busy, done, err
  );

  modport slave (
    input  clk0en, align, cfg_req,
    input  cfg_fd0, cfg_fd2, cfg_mask,
    output fd0, fd2, fdload,
    output busy, done, err
  );
endinterface

// File: rtl/cgu_fdload_seq.sv
// cgu_fdload_seq: shadowed fd0/fd2 reprogramming sequencer for clock-enable dividers.
// Define CGU_FDSEQ_TIMEOUT_EN to enable the WAIT_ALIGN timeout and err flag.
module cgu_fdload_seq #(
  parameter int FDW    = 8,
  parameter int NDOM   = 4,
  parameter int FD0RST = 127,
  parameter int SETTLE = 4,
  parameter int TMO    = 1023
) (
  input logic             clk,
  input logic             reset,
  cgu_fdload_seq_if.slave bus
);
  localparam int W = NDOM * FDW;
  localparam logic [FDW-1:0] FD0R = FDW'(FD0RST);
  localparam logic [7:0] SLAST = 8'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_SETTLE,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [W-1:0]    sh_fd0_q, sh_fd0_d;
  logic [W-1:0]    sh_fd2_q, sh_fd2_d;
  logic [NDOM-1:0] sh_mask_q, sh_mask_d;
  logic [W-1:0]    fd0_q, fd0_d;
  logic [W-1:0]    fd2_q, fd2_d;
  logic [NDOM-1:0] fdload_q;
  logic [7:0]      cnt_q;
  logic            pend_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            tmo_hit;

  // Shadow is forwarded so a request on the align cycle is the one loaded.
  always_comb begin
    sh_fd0_d  = bus.cfg_req ? bus.cfg_fd0  : sh_fd0_q;
    sh_fd2_d  = bus.cfg_req ? bus.cfg_fd2  : sh_fd2_q;
    sh_mask_d = bus.cfg_req ? bus.cfg_mask : sh_mask_q;
    fd0_d     = fd0_q;
    fd2_d     = fd2_q;
    for (int i = 0; i < NDOM; i++) begin
      if (sh_mask_d[i]) begin
        fd0_d[i*FDW +: FDW] = sh_fd0_d[i*FDW +: FDW];
        fd2_d[i*FDW +: FDW] = sh_fd2_d[i*FDW +: FDW];
      end
    end
  end

`ifdef CGU_FDSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != S_WAIT) tmo_q <= '0;
    else if (bus.clk0en) tmo_q <= tmo_q + TW'(1);
  end

  assign tmo_hit = (tmo_q == TW'(TMO - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sh_fd0_q  <= '0;
      sh_fd2_q  <= '0;
      sh_mask_q <= '0;
      fd0_q     <= {NDOM{FD0R}};
      fd2_q     <= '0;
      fdload_q  <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sh_fd0_q  <= sh_fd0_d;
      sh_fd2_q  <= sh_fd2_d;
      sh_mask_q <= sh_mask_d;
      done_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.cfg_req) begin
            err_q <= 1'b0;
            if (bus.cfg_mask != '0) begin
              state_q <= S_WAIT;
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (bus.clk0en && (bus.align || tmo_hit)) begin
            state_q  <= S_LOAD;
            fdload_q <= sh_mask_d;
            fd0_q    <= fd0_d;
            fd2_q    <= fd2_d;
            if (!bus.align) err_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.cfg_req) pend_q <= 1'b1;
          if (bus.clk0en) begin
            fdload_q <= '0;
            cnt_q    <= '0;
            state_q  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (bus.cfg_req) pend_q <= 1'b1;
          if (bus.clk0en) begin
            if (cnt_q == SLAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        S_DONE: begin
          if (bus.cfg_req) pend_q <= 1'b1;
          if (bus.clk0en) begin
            pend_q <= 1'b0;
            if (pend_q || bus.cfg_req) begin
              state_q <= S_WAIT;
              busy_q  <= 1'b1;
              err_q   <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Gated by the root enable so a held LOAD never strobes on a dead cycle.
  assign bus.fdload = fdload_q & {NDOM{bus.clk0en}};
  assign bus.fd0    = fd0_q;
  assign bus.fd2    = fd2_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_cgu_fdload_seq.sv
// tb_cgu_fdload_seq: table vectors plus hand sequences for the fdload sequencer.
// Expected loads go through a scoreboard queue, popped when fdload strobes.
module tb_cgu_fdload_seq;
  localparam int SETTLE = 4;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] f0;
    logic [31:0] f2;
    int          adly;
    logic [31:0] e0;
    logic [31:0] e2;
  } vec_t;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] e0;
    logic [31:0] e2;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t tbl[4];

  cgu_fdload_seq_if #(.FDW(8), .NDOM(4)) ifc ();

  cgu_fdload_seq #(
    .FDW(8), .NDOM(4), .FD0RST(127),
    .SETTLE(SETTLE), .TMO(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(logic [3:0] m, logic [31:0] f0, logic [31:0] f2,
                      logic [31:0] e0, logic [31:0] e2);
    exp_t e;
    e = '{m, e0, e2};
    sb.push_back(e);
    ifc.cfg_req  = 1'b1;
    ifc.cfg_mask = m;
    ifc.cfg_fd0  = f0;
    ifc.cfg_fd2  = f2;
    tick();
    ifc.cfg_req = 1'b0;
  endtask

  task automatic expect_load();
    exp_t e;
    if (sb.size() == 0) begin
      n_run++;
      n_fail++;
      $display("FAIL sb_empty: got fdload %h, expected no load", ifc.fdload);
    end else begin
      e = sb.pop_front();
      chk("fdload", 32'(ifc.fdload), 32'(e.mask));
      chk("fd0", ifc.fd0, e.e0);
      chk("fd2", ifc.fd2, e.e2);
    end
  endtask

  task automatic align_load();
    ifc.align = 1'b1;
    tick();
    ifc.align = 1'b0;
    expect_load();
  endtask

  task automatic wait_done(int exp_lat);
    int lat = 0;
    int extra = 0;
    while (!ifc.done && lat < 40) begin
      tick();
      lat++;
      if (ifc.fdload != '0) extra++;
    end
    chk("done_lat", lat, exp_lat);
    chk("busy_at_done", 32'(ifc.busy), 32'd0);
    chk("fdload_once", extra, 0);
  endtask

  task automatic run_vec(vec_t v);
    send(v.mask, v.f0, v.f2, v.e0, v.e2);
    chk("busy_rise", 32'(ifc.busy), 32'd1);
    repeat (v.adly) tick();
    chk("no_early_load", 32'(ifc.fdload), 32'd0);
    align_load();
    wait_done(SETTLE + 1);
    tick();
    chk("done_1cyc", 32'(ifc.done), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t post;
    int   ld_cnt, en_cnt, bad;
    bit   seen, got;

    tbl[0] = '{4'b0010, 32'h11220344, 32'h55660177, 5,
               32'h7F7F037F, 32'h00000100};
    tbl[1] = '{4'b1001, 32'h10203040, 32'h01020304, 0,
               32'h107F0340, 32'h01000104};
    tbl[2] = '{4'b0110, 32'hAABBCCDD, 32'hEEFF1234, 2,
               32'h10BBCC40, 32'h01FF1204};
    tbl[3] = '{4'b1111, 32'h01020304, 32'h05060708, 1,
               32'h01020304, 32'h05060708};
    post   = '{4'b1000, 32'hC8000000, 32'h02000000, 3,
               32'hC87F7F7F, 32'h02000000};

    ifc.clk0en   = 1'b1;
    ifc.align    = 1'b0;
    ifc.cfg_req  = 1'b0;
    ifc.cfg_mask = '0;
    ifc.cfg_fd0  = '0;
    ifc.cfg_fd2  = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_fd0", ifc.fd0, 32'h7F7F7F7F);
    chk("rst_fd2", ifc.fd2, 32'h0);
    chk("rst_fdload", 32'(ifc.fdload), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_err", 32'(ifc.err), 32'd0);

    for (int i = 0; i < 4; i++) run_vec(tbl[i]);
    tick();

    // Empty mask: immediate done, nothing loaded.
    ifc.cfg_req  = 1'b1;
    ifc.cfg_mask = 4'b0000;
    ifc.cfg_fd0  = 32'hFFFFFFFF;
    ifc.cfg_fd2  = 32'hFFFFFFFF;
    tick();
    ifc.cfg_req = 1'b0;
    chk("m0_done", 32'(ifc.done), 32'd1);
    chk("m0_busy", 32'(ifc.busy), 32'd0);
    chk("m0_fdload", 32'(ifc.fdload), 32'd0);
    chk("m0_fd0", ifc.fd0, 32'h01020304);
    chk("m0_fd2", ifc.fd2, 32'h05060708);
    tick();
    chk("m0_done_1cyc", 32'(ifc.done), 32'd0);
    tick();

    // Toggling root enable through WAIT_ALIGN, LOAD and SETTLE.
    send(4'b0100, 32'h005A0000, 32'h003C0000, 32'h015A0304, 32'h053C0708);
    ld_cnt = 0;
    en_cnt = 0;
    bad    = 0;
    seen   = 1'b0;
    got    = 1'b0;
    ifc.align = 1'b1;
    for (int t = 0; t < 80 && !got; t++) begin
      ifc.clk0en = t[0];
      #1;
      if (ifc.fdload != '0) begin
        ld_cnt++;
        if (!ifc.clk0en) bad++;
        if (ld_cnt == 1) begin
          expect_load();
          ifc.align = 1'b0;
        end
        seen = 1'b1;
      end
      if (seen && ifc.clk0en) en_cnt++;
      @(posedge clk);
      #1;
      if (ifc.done) got = 1'b1;
    end
    ifc.align = 1'b0;
    chk("gate_done_seen", 32'(got), 32'd1);
    chk("gate_no_dead_load", bad, 0);
    chk("gate_load_cnt", ld_cnt, 1);
    chk("gate_en_edges", en_cnt, SETTLE + 1);
    ifc.clk0en = 1'b1;
    tick();
    tick();

    // Second request during SETTLE is replayed after done.
    send(4'b0001, 32'h00000011, 32'h00000022, 32'h015A0311, 32'h053C0722);
    align_load();
    tick();
    tick();
    send(4'b0001, 32'h00000009, 32'h00000007, 32'h015A0309, 32'h053C0707);
    wait_done(SETTLE + 1 - 3);
    tick();
    chk("replay_busy", 32'(ifc.busy), 32'd1);
    chk("replay_done_low", 32'(ifc.done), 32'd0);
    repeat (2) tick();
    align_load();
    wait_done(SETTLE + 1);
    tick();
    chk("replay_idle_busy", 32'(ifc.busy), 32'd0);

    // Reset during SETTLE with a pending request queued.
    send(4'b0100, 32'h00770000, 32'h00660000, 32'h01770309, 32'h05660707);
    align_load();
    tick();
    tick();
    ifc.cfg_req  = 1'b1;
    ifc.cfg_mask = 4'b1111;
    ifc.cfg_fd0  = 32'hFFFFFFFF;
    tick();
    ifc.cfg_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_fd0", ifc.fd0, 32'h7F7F7F7F);
    chk("mid_rst_fd2", ifc.fd2, 32'h0);
    chk("mid_rst_fdload", 32'(ifc.fdload), 32'd0);
    chk("mid_rst_busy", 32'(ifc.busy), 32'd0);
    chk("mid_rst_done", 32'(ifc.done), 32'd0);
    repeat (3) tick();
    chk("pend_lost", 32'(ifc.busy), 32'd0);
    run_vec(post);

`ifdef CGU_FDSEQ_TIMEOUT_EN
    begin
      int   n;
      vec_t nxt;
      tick();
      send(4'b0001, 32'h00000044, 32'h00000001, 32'hC87F7F44, 32'h02000001);
      n = 0;
      while (ifc.fdload == '0 && n < 100) begin
        tick();
        n++;
      end
      chk("tmo_lat", n, 16);
      expect_load();
      chk("tmo_err_set", 32'(ifc.err), 32'd1);
      wait_done(SETTLE + 1);
      tick();
      chk("tmo_err_sticky", 32'(ifc.err), 32'd1);
      nxt = '{4'b0010, 32'h00005500, 32'h00000300, 1,
              32'hC87F5544, 32'h02000301};
      run_vec(nxt);
      chk("tmo_err_clr", 32'(ifc.err), 32'd0);
    end
`endif

    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
